// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types, sizes and the active-low grant encoding for the round-robin decoder arbiter.
package decoder_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // Active-low one-hot select: only the selected line is pulled low, and only while enabled.
    function automatic logic [NUM_REQ-1:0] onehot_n(input logic [SEL_W-1:0] sel, input logic en);
        logic [NUM_REQ-1:0] w_one;
        logic [NUM_REQ-1:0] w_res;
        w_one = {{(NUM_REQ-1){1'b0}}, 1'b1};
        if (en) begin
            w_res = ~(w_one << sel);
        end else begin
            w_res = {NUM_REQ{1'b1}};
        end
        return w_res;
    endfunction

endpackage

// File: rtl/decoder_rr_arbiter_rr_pick8.sv
// Combinational round-robin pick: the requester just after 'last' has top priority,
// and 'last' itself is scanned last.
module rr_pick8
    import decoder_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   winner
);

    logic [SEL_W-1:0]     w_base;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]     w_off;

    // Rotate so that bit 0 of w_rot is requester (last+1); 3-bit add wraps modulo 8.
    assign w_base = last + 3'd1;
    assign w_dbl  = {req, req} >> w_base;
    assign w_rot  = w_dbl[NUM_REQ-1:0];
    assign any    = |req;

    // Priority-encode the rotated vector: lowest set bit wins.
    always_comb begin
        w_off = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_off = w_rot[i] ? 3'(i) : w_off;
        end
    end

    // Un-rotate back to an absolute requester index.
    assign winner = w_base + w_off;

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Eight-way round-robin arbiter driving a shared 3-to-8 active-low select, with
// tenure limit, owner release and a guard gap between successive owners.
module decoder_rr_arbiter
    import decoder_arb_pkg::*;
#(
    parameter int HOLD_MAX   = 16,
    parameter int GAP_CYCLES = 1
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic               en,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt_n,
    output logic               busy,
    output logic               timeout
);

    localparam int HOLD_W = ($clog2(HOLD_MAX + 1) > 1) ? $clog2(HOLD_MAX + 1) : 1;
    localparam int GAP_W  = ($clog2(GAP_CYCLES + 1) > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam bit HOLD_EN = (HOLD_MAX != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX > 0) ? (HOLD_MAX - 1) : 0);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [SEL_W-1:0]    r_last;
    logic [SEL_W-1:0]    w_last_nxt;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [GAP_W-1:0]    r_gap;
    logic [GAP_W-1:0]    w_gap_nxt;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic                r_en;
    logic [NUM_REQ-1:0]  r_gnt_n;
    logic                r_busy;
    logic                r_timeout;
    logic                w_timeout_nxt;
    logic                w_limit;
    logic                w_owner_req;
    logic                w_any;
    logic [SEL_W-1:0]    w_winner;

    rr_pick8 u_pick (
        .req    (req),
        .last   (r_last),
        .any    (w_any),
        .winner (w_winner)
    );

    // Next-state logic: pick in IDLE, watch release conditions in GRANT, count out the GAP.
    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_hold_nxt    = r_hold;
        w_gap_nxt     = r_gap;
        w_sel_nxt     = r_sel;
        w_timeout_nxt = 1'b0;
        w_owner_req   = req[r_sel];
        w_limit       = HOLD_EN && (r_hold == HOLD_LAST);
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_winner;
                    w_last_nxt  = w_winner;
                    w_hold_nxt  = {HOLD_W{1'b0}};
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (done || !w_owner_req || w_limit) begin
                    w_state_nxt   = GAP;
                    w_gap_nxt     = {GAP_W{1'b0}};
                    // Only a revocation forced purely by the hold limit is a timeout.
                    w_timeout_nxt = w_limit && !done && w_owner_req;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; outputs are computed from next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= 3'd7;
            r_hold    <= {HOLD_W{1'b0}};
            r_gap     <= {GAP_W{1'b0}};
            r_sel     <= 3'd0;
            r_en      <= 1'b0;
            r_gnt_n   <= 8'hFF;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_hold    <= w_hold_nxt;
            r_gap     <= w_gap_nxt;
            r_sel     <= w_sel_nxt;
            r_en      <= (w_state_nxt == GRANT);
            r_gnt_n   <= onehot_n(w_sel_nxt, (w_state_nxt == GRANT));
            r_busy    <= (w_state_nxt != IDLE);
            r_timeout <= w_timeout_nxt;
        end
    end

    assign en      = r_en;
    assign sel     = r_sel;
    assign gnt_n   = r_gnt_n;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter: expected owners are queued when requests
// are driven and compared when the grant appears; timing checks run inline.
module tb_decoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic       en;
    logic [2:0] sel;
    logic [7:0] gnt_n;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    decoder_rr_arbiter #(.HOLD_MAX(4), .GAP_CYCLES(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .en      (en),
        .sel     (sel),
        .gnt_n   (gnt_n),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_gnt(input int idx);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << idx);
    endfunction

    // Advance to the next falling edge; done is a single-cycle pulse.
    task automatic tick();
        @(negedge clk);
        done = 1'b0;
    endtask

    // Wait (bounded) for a grant, then pop the expected owner and compare.
    task automatic wait_grant(input string tag, output int idle);
        int exp_idx;
        idle = 0;
        do begin
            tick();
            if (en !== 1'b1) idle++;
        end while (en !== 1'b1 && idle < 20);
        if (en !== 1'b1) check({tag, "_wait"}, 32'd0, 32'd1);
        exp_idx = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check({tag, "_sel"}, 32'(sel), exp_idx);
        check({tag, "_gnt"}, 32'(gnt_n), 32'(exp_gnt(exp_idx)));
    endtask

    // Count cycles with en=1, starting at the first granted cycle.
    task automatic hold_len(output int len);
        len = 1;
        tick();
        while (en === 1'b1 && len < 20) begin
            len++;
            tick();
        end
    endtask

    initial begin
        int idle;
        int len;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_en", 32'(en), 32'd0);
        check("rst_gnt", 32'(gnt_n), 32'hFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_to", 32'(timeout), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        rst = 1'b0;

        // Single request, done, gap, idle
        req = 8'h08;
        exp_q.push_back(3);
        wait_grant("t2", idle);
        check("t2_busy", 32'(busy), 32'd1);
        done = 1'b1;
        req = 8'h00;
        tick();
        check("t2_gap_gnt", 32'(gnt_n), 32'hFF);
        check("t2_gap_busy", 32'(busy), 32'd1);
        check("t2_gap_to", 32'(timeout), 32'd0);
        tick();
        check("t2_idle_busy", 32'(busy), 32'd0);

        // done pulsed in IDLE has no effect
        done = 1'b1;
        tick();
        tick();
        check("idle_done_en", 32'(en), 32'd0);
        check("idle_done_busy", 32'(busy), 32'd0);

        // Mid-stream async reset, visible without a clock edge
        req = 8'hFF;
        exp_q.push_back(4);
        wait_grant("t1pre", idle);
        #1 rst = 1'b1;
        #1;
        check("t1_en", 32'(en), 32'd0);
        check("t1_gnt", 32'(gnt_n), 32'hFF);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_to", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full rotation after reset: 0..7 then 0, two idle cycles between grants
        for (int k = 0; k < 9; k++) exp_q.push_back(k % 8);
        for (int k = 0; k < 9; k++) begin
            wait_grant("t3", idle);
            if (k > 0) check("t3_gap", idle, 2);
            if (k == 8) req = 8'h00;
            done = 1'b1;
        end
        tick();
        tick();

        // Hold limit: exactly 4 granted cycles, then timeout pulse, then re-grant
        req = 8'h20;
        exp_q.push_back(5);
        wait_grant("t4", idle);
        hold_len(len);
        check("t4_len", len, 4);
        check("t4_to", 32'(timeout), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        tick();
        check("t4_to_end", 32'(timeout), 32'd0);
        exp_q.push_back(5);
        wait_grant("t4re", idle);
        done = 1'b1;
        req = 8'h00;
        tick();
        tick();

        // Fairness after timeout: 0 times out, then 5, 0, 5 alternate
        req = 8'h01;
        exp_q.push_back(0);
        wait_grant("t5a", idle);
        hold_len(len);
        check("t5a_to", 32'(timeout), 32'd1);
        req = 8'h21;
        exp_q.push_back(5);
        exp_q.push_back(0);
        exp_q.push_back(5);
        for (int k = 0; k < 3; k++) begin
            wait_grant("t5", idle);
            hold_len(len);
            check("t5_len", len, 4);
            check("t5_to", 32'(timeout), 32'd1);
        end
        req = 8'h00;
        tick();

        // done coinciding with the hold limit: normal release, no timeout
        req = 8'h40;
        exp_q.push_back(6);
        wait_grant("t6", idle);
        tick();
        tick();
        tick();
        check("t6_en_last", 32'(en), 32'd1);
        done = 1'b1;
        tick();
        check("t6_en", 32'(en), 32'd0);
        check("t6_to", 32'(timeout), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        req = 8'h00;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
